// File: rtl/ssd_bcd_scanner_if.sv
// Display-stage bus: binary value in, scanned anode/segment drive and BCD result out.
interface ssd_bcd_scanner_if #(
  parameter int BIN_W = 13
);
  logic [BIN_W-1:0] bin_in;
  logic [3:0]       Anode;
  logic [6:0]       LED_out;
  logic [15:0]      bcd_out;
  logic             conv_done;

  modport master (
    output bin_in,
    input  Anode,
    input  LED_out,
    input  bcd_out,
    input  conv_done
  );

  modport slave (
    input  bin_in,
    output Anode,
    output LED_out,
    output bcd_out,
    output conv_done
  );
endinterface

// File: rtl/ssd_bcd_scanner.sv
// Binary-to-BCD converter (sequential double-dabble) feeding a 4-digit
// common-anode seven-segment scanner with optional leading-zero blanking.
// bus must be instantiated with the same BIN_W as this module.
module ssd_bcd_scanner #(
  parameter int BIN_W     = 13,
  parameter int REFRESH_W = 18,
  parameter int LZ_BLANK  = 1
) (
  input logic              clk,
  input logic              rst,
  ssd_bcd_scanner_if.slave bus
);

  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W + 1) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]           state;
  logic [BIN_W-1:0]     bin_sr;
  logic [15:0]          bcd_acc;
  logic [15:0]          bcd_adj;
  logic [CNT_W-1:0]     bit_cnt;
  logic [15:0]          bcd_r;
  logic                 done_r;

  logic [REFRESH_W-1:0] refresh_cnt;
  logic [1:0]           idx;
  logic [3:0]           digit;
  logic                 blank;
  logic [6:0]           seg;
  logic [3:0]           anode_r;
  logic [6:0]           led_r;

  // Double-dabble correction: add 3 to every nibble that is 5 or more.
  always_comb begin
    bcd_adj = bcd_acc;
    for (int unsigned i = 0; i < 4; i++) begin
      if (bcd_acc[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_acc[4*i +: 4] + 4'd3;
      end
    end
  end

  // Converter FSM: capture, shift BIN_W times, publish the finished result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      bin_sr  <= '0;
      bcd_acc <= '0;
      bit_cnt <= '0;
      bcd_r   <= '0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          bin_sr  <= bus.bin_in;
          bcd_acc <= '0;
          bit_cnt <= '0;
          state   <= ST_SHIFT;
        end
        ST_SHIFT: begin
          bcd_acc <= {bcd_adj[14:0], bin_sr[BIN_W-1]};
          bin_sr  <= bin_sr << 1;
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == CNT_W'(BIN_W - 1)) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          bcd_r  <= bcd_acc;
          done_r <= 1'b1;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign idx   = refresh_cnt[REFRESH_W-1 -: 2];
  assign digit = bcd_r[{idx, 2'b00} +: 4];

  // Leading-zero test: a digit above the ones place is blank when it and all higher digits are zero.
  always_comb begin
    blank = 1'b0;
    if (LZ_BLANK != 0) begin
      case (idx)
        2'd1:    blank = (bcd_r[15:4]  == 12'd0);
        2'd2:    blank = (bcd_r[15:8]  == 8'd0);
        2'd3:    blank = (bcd_r[15:12] == 4'd0);
        default: blank = 1'b0;
      endcase
    end
  end

  // Active-low segment decode {a,b,c,d,e,f,g}; non-decimal nibbles are dark.
  always_comb begin
    case (digit)
      4'd0:    seg = 7'b0000001;
      4'd1:    seg = 7'b1001111;
      4'd2:    seg = 7'b0010010;
      4'd3:    seg = 7'b0000110;
      4'd4:    seg = 7'b1001100;
      4'd5:    seg = 7'b0100100;
      4'd6:    seg = 7'b0100000;
      4'd7:    seg = 7'b0001111;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0000100;
      default: seg = 7'b1111111;
    endcase
  end

  // Scanner: free-running refresh counter and registered anode/segment drive.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      refresh_cnt <= '0;
      anode_r     <= 4'b1111;
      led_r       <= 7'b1111111;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
      anode_r     <= ~(4'b0001 << idx);
      led_r       <= blank ? 7'b1111111 : seg;
    end
  end

  assign bus.bcd_out   = bcd_r;
  assign bus.conv_done = done_r;
  assign bus.Anode     = anode_r;
  assign bus.LED_out   = led_r;

endmodule

// File: tb/tb_ssd_bcd_scanner.sv
// Directed bench for ssd_bcd_scanner (BIN_W=13, REFRESH_W=4), one blanking and one non-blanking instance.
module tb_ssd_bcd_scanner;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  ssd_bcd_scanner_if #(.BIN_W(13)) if1 ();
  ssd_bcd_scanner_if #(.BIN_W(13)) if0 ();

  ssd_bcd_scanner #(.BIN_W(13), .REFRESH_W(4), .LZ_BLANK(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  ssd_bcd_scanner #(.BIN_W(13), .REFRESH_W(4), .LZ_BLANK(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_bin(input logic [12:0] v);
    if1.bin_in = v;
    if0.bin_in = v;
  endtask

  // Cycles (posedges) until conv_done is seen high on dut1; -1 if none within budget.
  task automatic wait_done(output int cyc);
    bit hit;
    hit = 1'b0;
    cyc = 0;
    while (!hit && cyc < 60) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (if1.conv_done) hit = 1'b1;
    end
    if (!hit) cyc = -1;
  endtask

  // Collect LED_out for each anode slot over one full scan; segs[7*i+:7] is slot i.
  task automatic capture(input bit which, output logic [27:0] segs,
                         output logic [3:0] seen, output bit odd);
    logic [3:0] an;
    logic [6:0] led;
    segs = '1;
    seen = '0;
    odd  = 1'b0;
    repeat (16) begin
      @(negedge clk);
      an  = which ? if0.Anode   : if1.Anode;
      led = which ? if0.LED_out : if1.LED_out;
      case (an)
        4'b1110: begin segs[6:0]   = led; seen[0] = 1'b1; end
        4'b1101: begin segs[13:7]  = led; seen[1] = 1'b1; end
        4'b1011: begin segs[20:14] = led; seen[2] = 1'b1; end
        4'b0111: begin segs[27:21] = led; seen[3] = 1'b1; end
        default: odd = 1'b1;
      endcase
    end
  endtask

  task automatic test_reset;
    int c1;
    int c;
    logic [27:0] segs;
    logic [3:0]  seen;
    bit          odd;
    rst = 1'b0;
    set_bin(13'd0);
    #23;
    total++; if (if1.Anode !== 4'b1111) begin bad++; $display("FAIL rst_anode got=%b exp=1111", if1.Anode); end
    total++; if (if1.LED_out !== 7'b1111111) begin bad++; $display("FAIL rst_led got=%b exp=1111111", if1.LED_out); end
    total++; if (if1.conv_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", if1.conv_done); end
    total++; if (if1.bcd_out !== 16'h0000) begin bad++; $display("FAIL rst_bcd got=%h exp=0000", if1.bcd_out); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    c1 = 1;
    total++; if (if1.Anode !== 4'b1110) begin bad++; $display("FAIL rel_anode got=%b exp=1110", if1.Anode); end
    total++; if (if1.LED_out !== 7'b0000001) begin bad++; $display("FAIL rel_led got=%b exp=0000001", if1.LED_out); end
    total++; if (if1.conv_done !== 1'b0) begin bad++; $display("FAIL rel_done_early got=%b exp=0", if1.conv_done); end
    wait_done(c);
    total++; if (c + c1 !== 15) begin bad++; $display("FAIL first_done_cycle got=%0d exp=15", c + c1); end
    total++; if (if1.bcd_out !== 16'h0000) begin bad++; $display("FAIL zero_bcd got=%h exp=0000", if1.bcd_out); end
    wait_done(c);
    total++; if (c !== 15) begin bad++; $display("FAIL done_period got=%0d exp=15", c); end
    capture(1'b0, segs, seen, odd);
    total++; if (seen !== 4'hF || odd) begin bad++; $display("FAIL zero_scan got=%b/%b exp=1111/0", seen, odd); end
    total++; if (segs !== {7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001})
      begin bad++; $display("FAIL zero_segs got=%h exp=%h", segs, {7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001}); end
  endtask

  task automatic test_convert;
    int c;
    logic [27:0] segs;
    logic [3:0]  seen;
    bit          odd;
    set_bin(13'd1234);
    wait_done(c);
    wait_done(c);
    total++; if (if1.bcd_out !== 16'h1234) begin bad++; $display("FAIL bcd_1234 got=%h exp=1234", if1.bcd_out); end
    total++; if (c !== 15) begin bad++; $display("FAIL period_1234 got=%0d exp=15", c); end
    capture(1'b0, segs, seen, odd);
    total++; if (seen !== 4'hF || odd) begin bad++; $display("FAIL scan_1234 got=%b/%b exp=1111/0", seen, odd); end
    total++; if (segs !== {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100})
      begin bad++; $display("FAIL segs_1234 got=%h exp=%h", segs, {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}); end
  endtask

  task automatic test_max;
    int c;
    logic [27:0] segs;
    logic [3:0]  seen;
    bit          odd;
    set_bin(13'd8191);
    wait_done(c);
    wait_done(c);
    total++; if (if1.bcd_out !== 16'h8191) begin bad++; $display("FAIL bcd_8191 got=%h exp=8191", if1.bcd_out); end
    capture(1'b0, segs, seen, odd);
    total++; if (segs !== {7'b0000000, 7'b1001111, 7'b0000100, 7'b1001111})
      begin bad++; $display("FAIL segs_8191 got=%h exp=%h", segs, {7'b0000000, 7'b1001111, 7'b0000100, 7'b1001111}); end
  endtask

  task automatic test_lz_blank;
    int c;
    logic [27:0] segs;
    logic [3:0]  seen;
    bit          odd;
    set_bin(13'd7);
    wait_done(c);
    wait_done(c);
    total++; if (if1.bcd_out !== 16'h0007) begin bad++; $display("FAIL bcd_7 got=%h exp=0007", if1.bcd_out); end
    capture(1'b0, segs, seen, odd);
    total++; if (segs !== {7'b1111111, 7'b1111111, 7'b1111111, 7'b0001111})
      begin bad++; $display("FAIL lz1_segs_7 got=%h exp=%h", segs, {7'b1111111, 7'b1111111, 7'b1111111, 7'b0001111}); end
    capture(1'b1, segs, seen, odd);
    total++; if (seen !== 4'hF || odd) begin bad++; $display("FAIL lz0_scan got=%b/%b exp=1111/0", seen, odd); end
    total++; if (segs !== {7'b0000001, 7'b0000001, 7'b0000001, 7'b0001111})
      begin bad++; $display("FAIL lz0_segs_7 got=%h exp=%h", segs, {7'b0000001, 7'b0000001, 7'b0000001, 7'b0001111}); end
    set_bin(13'd105);
    wait_done(c);
    wait_done(c);
    capture(1'b0, segs, seen, odd);
    total++; if (segs !== {7'b1111111, 7'b1001111, 7'b0000001, 7'b0100100})
      begin bad++; $display("FAIL lz1_segs_105 got=%h exp=%h", segs, {7'b1111111, 7'b1001111, 7'b0000001, 7'b0100100}); end
  endtask

  task automatic test_midchange;
    int c;
    set_bin(13'd1234);
    wait_done(c);
    wait_done(c);
    repeat (3) @(posedge clk);
    @(negedge clk);
    set_bin(13'd4321);
    wait_done(c);
    total++; if (if1.bcd_out !== 16'h1234) begin bad++; $display("FAIL inflight_bcd got=%h exp=1234", if1.bcd_out); end
    total++; if (c !== 12) begin bad++; $display("FAIL inflight_cycle got=%0d exp=12", c); end
    wait_done(c);
    total++; if (if1.bcd_out !== 16'h4321) begin bad++; $display("FAIL next_bcd got=%h exp=4321", if1.bcd_out); end
  endtask

  task automatic test_reset_mid;
    int c;
    bit pulsed;
    set_bin(13'd1234);
    wait_done(c);
    wait_done(c);
    total++; if (if1.bcd_out !== 16'h1234) begin bad++; $display("FAIL pre_rst_bcd got=%h exp=1234", if1.bcd_out); end
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (if1.bcd_out !== 16'h0000) begin bad++; $display("FAIL midrst_bcd got=%h exp=0000", if1.bcd_out); end
    total++; if (if1.Anode !== 4'b1111) begin bad++; $display("FAIL midrst_anode got=%b exp=1111", if1.Anode); end
    total++; if (if1.LED_out !== 7'b1111111) begin bad++; $display("FAIL midrst_led got=%b exp=1111111", if1.LED_out); end
    pulsed = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (if1.conv_done !== 1'b0) pulsed = 1'b1;
    end
    total++; if (pulsed) begin bad++; $display("FAIL midrst_done got=1 exp=0"); end
    rst = 1'b1;
    wait_done(c);
    total++; if (c !== 15) begin bad++; $display("FAIL restart_cycle got=%0d exp=15", c); end
    total++; if (if1.bcd_out !== 16'h1234) begin bad++; $display("FAIL restart_bcd got=%h exp=1234", if1.bcd_out); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    set_bin(13'd0);
    test_reset();
    test_convert();
    test_max();
    test_lz_blank();
    test_midchange();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
